// File: rtl/fft_pkg.sv
// Shared sizing defaults and the index bit-reversal helper for the FFT input path.
package fft_pkg;
  localparam int DATA_WIDTH  = 32;
  localparam int LOG2_NFFT   = 5;
  localparam int NFFT_POINTS = 1 << LOG2_NFFT;
  localparam int FRAME_W     = NFFT_POINTS * DATA_WIDTH;

  // Reverses the low nbits of idx; bits above nbits come back as zero.
  function automatic int unsigned bitrev(input int unsigned idx, input int unsigned nbits);
    int unsigned r;
    r = 0;
    for (int b = 0; b < 32; b++) begin
      if (b < nbits) r[b] = idx[nbits - 1 - b];
    end
    return r;
  endfunction
endpackage

// File: rtl/fft_frame_bank.sv
// One frame bank: NFFT complex words, single write port, whole contents exposed flat.
module fft_frame_bank #(
  parameter int DW = 32,
  parameter int NP = 32,
  parameter int AW = 5
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           we_i,
  input  logic [AW-1:0]  waddr_i,
  input  logic [DW-1:0]  wdata_r_i,
  input  logic [DW-1:0]  wdata_im_i,
  output logic [NP*DW-1:0] frame_r_o,
  output logic [NP*DW-1:0] frame_i_o
);
  logic [NP*DW-1:0] mem_r_q;
  logic [NP*DW-1:0] mem_i_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_r_q <= '0;
      mem_i_q <= '0;
    end else if (we_i) begin
      mem_r_q[waddr_i*DW +: DW] <= wdata_r_i;
      mem_i_q[waddr_i*DW +: DW] <= wdata_im_i;
    end
  end

  assign frame_r_o = mem_r_q;
  assign frame_i_o = mem_i_q;
endmodule

// File: rtl/fft_input_framer.sv
// Ping-pong framer: packs a valid/ready complex sample stream into parallel frames for the FFT core.
module fft_input_framer
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH  = fft_pkg::DATA_WIDTH,
  parameter int LOG2_NFFT   = fft_pkg::LOG2_NFFT,
  parameter int BIT_REVERSE = 0,
  localparam int NFFT_POINTS = 1 << LOG2_NFFT,
  localparam int FW          = NFFT_POINTS * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_r,
  input  logic [DATA_WIDTH-1:0] in_i,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic [FW-1:0]         frame_r,
  output logic [FW-1:0]         frame_i,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  frame_err,
  input  logic                  err_clr
);
  localparam int AW = LOG2_NFFT;

  logic [AW-1:0] wr_cnt_q, wr_cnt_d;
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [1:0]    full_q, full_d;
  logic          err_q, err_d;
  logic          accept, handshake, new_err;
  logic [AW-1:0] waddr;
  logic [FW-1:0] bank_r [2];
  logic [FW-1:0] bank_i [2];

  // Handshakes: a sample moves on in_valid & in_ready, a frame on frame_valid & frame_ready;
  // in_ready depends only on registered state.
  assign in_ready    = !full_q[wr_bank_q];
  assign frame_valid = full_q[rd_bank_q];
  assign accept      = in_valid & in_ready;
  assign handshake   = frame_valid & frame_ready;
  assign waddr       = (BIT_REVERSE != 0) ? AW'(bitrev(32'(wr_cnt_q), LOG2_NFFT)) : wr_cnt_q;

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    full_d    = full_q;
    new_err   = 1'b0;
    if (accept) begin
      if (wr_cnt_q == AW'(NFFT_POINTS - 1)) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = '0;
        new_err           = ~in_last;
      end else if (in_last) begin
        wr_cnt_d = '0;
        new_err  = 1'b1;
      end else begin
        wr_cnt_d = wr_cnt_q + AW'(1);
      end
    end
    // Completion targets a non-full bank and a handshake a full one, so they never collide.
    if (handshake) begin
      full_d[rd_bank_q] = 1'b0;
      rd_bank_d         = ~rd_bank_q;
    end
    err_d = new_err | (err_q & ~err_clr);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      err_q     <= err_d;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_frame_bank #(.DW(DATA_WIDTH), .NP(NFFT_POINTS), .AW(AW)) u_bank (
      .clk_i      (clk),
      .rst_ni     (rst),
      .we_i       (accept && (wr_bank_q == g[0])),
      .waddr_i    (waddr),
      .wdata_r_i  (in_r),
      .wdata_im_i (in_i),
      .frame_r_o  (bank_r[g]),
      .frame_i_o  (bank_i[g])
    );
  end

  assign frame_r   = bank_r[rd_bank_q];
  assign frame_i   = bank_i[rd_bank_q];
  assign frame_err = err_q;
endmodule
